// File: rtl/ram32x4_pkg.sv
// Shared constants and state type for the 32x4 RAM write and read sides.
package ram32x4_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } writer_state_t;

endpackage

// File: rtl/ram_addr_counter.sv
// Fill-address up-counter with enable, synchronous clear and terminal-count flag.
module ram_addr_counter #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              tc_o
);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == ADDR_W'(DEPTH - 1));

endmodule

// File: rtl/ram32x4_writer.sv
// Write-side controller for the 32x4 RAM: single handshaked writes or a bulk fill.
module ram32x4_writer #(
    parameter int ADDR_W = ram32x4_pkg::ADDR_W,
    parameter int DATA_W = ram32x4_pkg::DATA_W,
    parameter int DEPTH  = ram32x4_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              fill_done
);

    import ram32x4_pkg::*;

    writer_state_t     state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              fill_done_q, fill_done_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [ADDR_W-1:0] cnt_count;
    logic              cnt_tc;

    // The counter tracks the address currently on wr_addr during FILL.
    ram_addr_counter #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fill_cnt (
        .clk     (clk),
        .clr_i   (cnt_clr | rst),
        .en_i    (cnt_en),
        .count_o (cnt_count),
        .tc_o    (cnt_tc)
    );

    assign req_ready = (state_q == IDLE) && !rst && !fill_start;

    // Outputs are computed from the transition so they line up with the state being entered.
    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = 1'b0;
        fill_done_d = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d   = FILL;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = fill_value;
                    busy_d    = 1'b1;
                    cnt_clr   = 1'b1;
                end else if (req_valid) begin
                    state_d   = WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = req_addr;
                    wr_data_d = req_data;
                    busy_d    = 1'b1;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            FILL: begin
                busy_d = 1'b1;
                if (cnt_tc) begin
                    state_d     = DONE;
                    fill_done_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_count + ADDR_W'(1);
                    cnt_en    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign fill_done = fill_done_q;

endmodule

// File: tb/tb_ram32x4_writer.sv
// Bench for ram32x4_writer: directed scenarios then random traffic, checked against a cycle schedule model.
module tb_ram32x4_writer;

    import ram32x4_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              fill_start;
    logic [DATA_W-1:0] fill_value;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              fill_done;

    always #5 clk = ~clk;

    ram32x4_writer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .fill_done  (fill_done)
    );

    // One entry per future cycle of expected registered outputs.
    typedef struct {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;
        logic              done;
    } beat_t;

    beat_t pending[$];
    beat_t cur;
    int    checks   = 0;
    int    failures = 0;
    bit    accepted;
    bit    reached;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic expReady();
        return !cur.busy && !rst && !fill_start;
    endfunction

    task automatic modelEdge();
        beat_t b;
        if (rst) begin
            pending.delete();
            cur = '{1'b0, '0, '0, 1'b0, 1'b0};
        end else begin
            if (!cur.busy) begin
                if (fill_start) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        b = '{1'b1, k[ADDR_W-1:0], fill_value, 1'b1, 1'b0};
                        pending.push_back(b);
                    end
                    b = '{1'b0, ADDR_W'(DEPTH - 1), fill_value, 1'b1, 1'b1};
                    pending.push_back(b);
                end else if (req_valid) begin
                    b = '{1'b1, req_addr, req_data, 1'b1, 1'b0};
                    pending.push_back(b);
                end
            end
            if (pending.size() > 0) begin
                cur = pending.pop_front();
            end else begin
                cur = '{1'b0, cur.addr, cur.data, 1'b0, 1'b0};
            end
        end
    endtask

    task automatic applyStimulus();
        #1;
        checkOutput("req_ready", 32'(req_ready), 32'(expReady()));
        accepted = expReady() && req_valid;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("wr_en", 32'(wr_en), 32'(cur.en));
        checkOutput("busy", 32'(busy), 32'(cur.busy));
        checkOutput("fill_done", 32'(fill_done), 32'(cur.done));
        if (cur.en || rst) begin
            checkOutput("wr_addr", 32'(wr_addr), 32'(cur.addr));
            checkOutput("wr_data", 32'(wr_data), 32'(cur.data));
        end
    endtask

    task automatic waitAccept(input string tag, input int maxCycles);
        int n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!accepted && n < maxCycles);
        checkOutput(tag, 32'(accepted), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        fill_start = 1'b0;
        fill_value = '0;
        cur        = '{1'b0, '0, '0, 1'b0, 1'b0};

        @(posedge clk);
        @(negedge clk);
        applyStimulus();
        rst = 1'b0;
        applyStimulus();

        req_valid = 1'b1;
        req_addr  = 5'd7;
        req_data  = 4'hA;
        applyStimulus();
        checkOutput("single_accept", 32'(accepted), 32'd1);
        req_valid = 1'b0;
        checkOutput("single_wr_addr", 32'(wr_addr), 32'd7);
        checkOutput("single_wr_data", 32'(wr_data), 32'hA);
        applyStimulus();
        applyStimulus();

        req_valid = 1'b1;
        req_addr  = 5'd3;
        req_data  = 4'h1;
        waitAccept("b2b_first_accept", 4);
        req_addr  = 5'd4;
        req_data  = 4'h2;
        waitAccept("b2b_second_accept", 4);
        req_valid = 1'b0;
        repeat (3) applyStimulus();

        fill_start = 1'b1;
        fill_value = 4'h5;
        applyStimulus();
        fill_start = 1'b0;
        repeat (DEPTH + 3) applyStimulus();

        fill_start = 1'b1;
        fill_value = 4'h6;
        req_valid  = 1'b1;
        req_addr   = 5'd9;
        req_data   = 4'hC;
        applyStimulus();
        checkOutput("collision_not_accepted", 32'(accepted), 32'd0);
        fill_start = 1'b0;
        waitAccept("collision_late_accept", DEPTH + 6);
        req_valid = 1'b0;
        repeat (3) applyStimulus();

        fill_start = 1'b1;
        fill_value = 4'h3;
        applyStimulus();
        fill_start = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 40 && !reached; n++) begin
            if (cur.en && cur.addr == 5'd12) begin
                reached = 1'b1;
            end else begin
                applyStimulus();
            end
        end
        checkOutput("abort_reached_addr12", 32'(reached), 32'd1);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        repeat (DEPTH + 4) applyStimulus();

        for (int i = 0; i < 300; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            fill_start = ($urandom_range(0, 29) == 0);
            fill_value = DATA_W'($urandom);
            req_valid  = 1'($urandom_range(0, 1));
            req_addr   = ADDR_W'($urandom);
            req_data   = DATA_W'($urandom);
            applyStimulus();
        end
        rst        = 1'b0;
        fill_start = 1'b0;
        req_valid  = 1'b0;
        repeat (DEPTH + 4) applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
